// File: rtl/mux_2_1_rr_arb_pkg.sv
// Shared constants for the 2:1 round-robin packet arbiter: FSM state codes,
// source ids and a helper that maps a source to its lock state.
package mux_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOCK_A = 2'd1;
  localparam logic [1:0] ST_LOCK_B = 2'd2;

  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    LOCK_A = ST_LOCK_A,
    LOCK_B = ST_LOCK_B
  } state_t;

  function automatic state_t lock_of(input logic src);
    return (src == SRC_B) ? LOCK_B : LOCK_A;
  endfunction

endpackage

// File: rtl/mux_2_1_rr_pick_2.sv
// Combinational two-way round-robin pick. While a packet is locked the grant is
// pinned to the owner regardless of either request.
module rr_pick_2
  import mux_pkg::*;
(
  input  logic       req_a,
  input  logic       req_b,
  input  logic       ptr,
  input  logic [1:0] lock_state,
  output logic       grant,
  output logic       grant_vld
);

  always_comb begin
    grant     = SRC_A;
    grant_vld = 1'b0;
    if (lock_state == ST_LOCK_A) begin
      grant     = SRC_A;
      grant_vld = 1'b1;
    end else if (lock_state == ST_LOCK_B) begin
      grant     = SRC_B;
      grant_vld = 1'b1;
    end else if (req_a && req_b) begin
      // ptr is the last winner, so the other source goes next
      grant     = ~ptr;
      grant_vld = 1'b1;
    end else if (req_a) begin
      grant     = SRC_A;
      grant_vld = 1'b1;
    end else if (req_b) begin
      grant     = SRC_B;
      grant_vld = 1'b1;
    end
  end

endmodule

// File: rtl/mux_2_1_rr_arb.sv
// Two-source packet arbiter feeding a registered output stage; s tells the
// downstream 2:1 mux which source produced the registered beat.
module mux_2_1_rr_arb
  import mux_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int FIRST_B = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  input  logic             a_last,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
  input  logic             b_last,
  output logic             b_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  input  logic             out_ready,
  output logic             s,
  output logic [1:0]       state
);

  // valid/ready: a beat moves on x when x_valid & x_ready in the same cycle;
  // ready is granted only when the output register is empty or draining.
  state_t     state_q;
  logic       ptr_q;
  logic       grant;
  logic       grant_vld;
  logic       load;
  logic       xfer;
  logic [WIDTH-1:0] sel_data;
  logic       sel_last;

  rr_pick_2 u_pick (
    .req_a      (a_valid),
    .req_b      (b_valid),
    .ptr        (ptr_q),
    .lock_state (state_q),
    .grant      (grant),
    .grant_vld  (grant_vld)
  );

  assign load     = !out_valid || out_ready;
  assign a_ready  = load && grant_vld && (grant == SRC_A);
  assign b_ready  = load && grant_vld && (grant == SRC_B);
  assign xfer     = (a_valid && a_ready) || (b_valid && b_ready);
  assign sel_data = (grant == SRC_B) ? b_data : a_data;
  assign sel_last = (grant == SRC_B) ? b_last : a_last;
  assign state    = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      s         <= SRC_A;
      state_q   <= IDLE;
      ptr_q     <= (FIRST_B != 0) ? SRC_A : SRC_B;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= sel_data;
      out_last  <= sel_last;
      s         <= grant;
      if (sel_last) begin
        state_q <= IDLE;
        ptr_q   <= grant;
      end else begin
        state_q <= lock_of(grant);
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_2_1_rr_arb.sv
// Directed scenarios followed by random traffic, checked against a packet-level
// model of the arbiter (owner, last winner, one-deep output queue).
module tb_mux_2_1_rr_arb;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         a_valid, a_last, b_valid, b_last, out_ready;
  logic [W-1:0] a_data, b_data;
  logic         a_ready, b_ready, out_valid, out_last, s;
  logic [W-1:0] out_data;
  logic [1:0]   state;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  // model: owner -1 = no packet in progress, 0 = a, 1 = b
  int owner;
  int last_winner;
  logic [W+1:0] exp_q[$];   // {src, last, data} of the beat in the output register

  mux_2_1_rr_arb #(.WIDTH(W), .FIRST_B(0)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_data(a_data), .a_last(a_last), .a_ready(a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_last(b_last), .b_ready(b_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_ready(out_ready), .s(s), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    owner       = -1;
    last_winner = 1;   // FIRST_B=0: b counts as last winner so a goes first
  endtask

  // One clock: drive, check outputs and readies against the model, advance.
  task automatic cycle(input logic av, input logic [W-1:0] ad, input logic al,
                       input logic bv, input logic [W-1:0] bd, input logic bl,
                       input logic ordy);
    logic occ, can_take, ea, eb;
    int   g;
    a_valid = av; a_data = ad; a_last = al;
    b_valid = bv; b_data = bd; b_last = bl;
    out_ready = ordy;
    #1;
    occ      = (exp_q.size() != 0);
    can_take = !occ || ordy;
    g = -1;
    if (can_take) begin
      if (owner >= 0)      g = owner;
      else if (av && bv)   g = 1 - last_winner;
      else if (av)         g = 0;
      else if (bv)         g = 1;
    end
    ea = (g == 0);
    eb = (g == 1);
    chk("a_ready", {31'd0, a_ready}, {31'd0, ea});
    chk("b_ready", {31'd0, b_ready}, {31'd0, eb});
    chk("out_valid", {31'd0, out_valid}, {31'd0, occ});
    chk("state", {30'd0, state}, (owner < 0) ? 32'd0 : ((owner == 0) ? 32'd1 : 32'd2));
    if (occ) begin
      chk("out_data", {24'd0, out_data}, {24'd0, exp_q[0][W-1:0]});
      chk("out_last", {31'd0, out_last}, {31'd0, exp_q[0][W]});
      chk("s", {31'd0, s}, {31'd0, exp_q[0][W+1]});
    end
    if (occ && ordy) void'(exp_q.pop_front());
    if ((ea && av) || (eb && bv)) begin
      if (ea) exp_q.push_back({1'b0, al, ad});
      else    exp_q.push_back({1'b1, bl, bd});
      if ((ea && al) || (eb && bl)) begin
        owner       = -1;
        last_winner = ea ? 0 : 1;
      end else begin
        owner = ea ? 0 : 1;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // Asynchronous reset pulse in the middle of the low phase.
  task automatic pulse_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_state", {30'd0, state}, 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [W-1:0] seq2 [4];

  initial begin
    rst = 1'b1;
    a_valid = 0; a_data = '0; a_last = 0;
    b_valid = 0; b_data = '0; b_last = 0;
    out_ready = 0;
    model_reset();
    #3;
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_out_data", {24'd0, out_data}, 32'd0);
    chk("reset_out_last", {31'd0, out_last}, 32'd0);
    chk("reset_s", {31'd0, s}, 32'd0);
    chk("reset_state", {30'd0, state}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // 1: single-beat packet on a
    cycle(1, 8'h11, 1, 0, 8'h00, 0, 1);
    chk("t1_out_data", {24'd0, out_data}, 32'h11);
    chk("t1_s", {31'd0, s}, 32'd0);
    cycle(0, 8'h00, 0, 0, 8'h00, 0, 1);

    // 2: both sources with 1-beat packets alternate, a first after reset
    pulse_reset();
    seq2[0] = 8'hA0; seq2[1] = 8'hB0; seq2[2] = 8'hA0; seq2[3] = 8'hB0;
    for (int i = 0; i < 4; i++) begin
      cycle(1, 8'hA0, 1, 1, 8'hB0, 1, 1);
      chk("t2_order", {24'd0, out_data}, {24'd0, seq2[i]});
      chk("t2_s", {31'd0, s}, (i % 2 == 0) ? 32'd0 : 32'd1);
    end

    // 3: 3-beat a packet holds off b
    cycle(1, 8'h01, 0, 1, 8'hB3, 1, 1);
    cycle(1, 8'h02, 0, 1, 8'hB3, 1, 1);
    cycle(1, 8'h03, 1, 1, 8'hB3, 1, 1);
    cycle(0, 8'h00, 0, 1, 8'hB3, 1, 1);
    chk("t3_b_after", {24'd0, out_data}, 32'hB3);

    // 4: downstream stall for 3 clocks, then drain
    for (int i = 0; i < 3; i++) cycle(1, 8'h44, 1, 1, 8'h55, 1, 0);
    for (int i = 0; i < 3; i++) cycle(1, 8'h44, 1, 1, 8'h55, 1, 1);

    // 5: reset while locked on b, then a wins
    cycle(0, 8'h00, 0, 0, 8'h00, 0, 1);
    cycle(0, 8'h00, 0, 1, 8'hB1, 0, 1);
    pulse_reset();
    cycle(1, 8'h5A, 1, 1, 8'hB2, 0, 1);
    chk("t5_a_first", {31'd0, s}, 32'd0);

    // 6: bubble inside a locked a packet, b waiting
    cycle(1, 8'h61, 0, 0, 8'h00, 0, 1);
    cycle(0, 8'h00, 0, 1, 8'hB6, 1, 1);
    cycle(0, 8'h00, 0, 1, 8'hB6, 1, 1);
    cycle(1, 8'h62, 1, 1, 8'hB6, 1, 1);
    chk("t6_a_last", {24'd0, out_data}, 32'h62);
    cycle(0, 8'h00, 0, 1, 8'hB6, 1, 1);
    chk("t6_b_next", {24'd0, out_data}, 32'hB6);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 2) == 0),
            1'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 3) != 0));
      if (i == 200) pulse_reset();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
